// File: rtl/app_sched_pkg.sv
// Shared definitions for the echo-app flow scheduler: default sizes and the
// round-robin pick helper used by both the dispatch and requeue arbiters.
package app_sched_pkg;

    localparam int NUM_CTRL  = 4;
    localparam int FLOWID_W  = 8;

    // Widest controller array supported; the helper works at this width and
    // callers truncate the result to their own size.
    localparam int MAX_CTRL  = 16;
    localparam int MAX_IDX_W = 4;

    typedef struct packed {
        logic                 any;
        logic [MAX_IDX_W-1:0] idx;
        logic [MAX_CTRL-1:0]  grant;
    } rr_pick_t;

    // First requester at or after ptr, wrapping inside a power-of-two window
    // described by mask (window size minus one).
    function automatic rr_pick_t rr_pick(input logic [MAX_CTRL-1:0]  req,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input logic [MAX_IDX_W-1:0] mask);
        rr_pick_t             r;
        logic [MAX_IDX_W-1:0] cand;
        r = '0;
        for (int k = 0; k < MAX_CTRL; k++) begin
            cand = (ptr + MAX_IDX_W'(k)) & mask;
            if (k <= int'(mask) && !r.any && req[cand]) begin
                r.any         = 1'b1;
                r.idx         = cand;
                r.grant[cand] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/flow_rr_arb.sv
// Round-robin picker over N requesters with an optional lock that forces the
// previously issued grant to stay in place until the caller releases it.
module flow_rr_arb
    import app_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          lock_i,
    input  logic [PW-1:0] lock_idx_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    rr_pick_t pick;

    assign pick = rr_pick(MAX_CTRL'(req_i), MAX_IDX_W'(ptr_i), MAX_IDX_W'(N - 1));

    // Locked grant wins over a fresh pick so a stalled grant cannot move.
    always_comb begin
        grant_o = N'(pick.grant);
        idx_o   = PW'(pick.idx);
        any_o   = pick.any;
        if (lock_i) begin
            grant_o = N'(1) << lock_idx_i;
            idx_o   = lock_idx_i;
            any_o   = 1'b1;
        end
    end

endmodule

// File: rtl/rpc_echo_app_flow_sched.sv
// Shares one flow FIFO between NUM_CTRL echo-app controllers: dispatches FIFO
// head IDs to idle controllers round-robin and funnels their requeues back.
module rpc_echo_app_flow_sched
    import app_sched_pkg::*;
#(
    parameter int NUM_CTRL = app_sched_pkg::NUM_CTRL,
    parameter int FLOWID_W = app_sched_pkg::FLOWID_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sched_en,
    input  logic                         flow_fifo_sched_flowid_val,
    input  logic [FLOWID_W-1:0]          flow_fifo_sched_flowid,
    output logic                         sched_flow_fifo_flowid_yumi,
    output logic                         sched_flow_fifo_enqueue_val,
    output logic [FLOWID_W-1:0]          sched_flow_fifo_enqueue_flowid,
    input  logic                         flow_fifo_sched_enqueue_rdy,
    output logic [NUM_CTRL-1:0]          sched_ctrl_flowid_val,
    output logic [FLOWID_W-1:0]          sched_ctrl_flowid,
    input  logic [NUM_CTRL-1:0]          ctrl_sched_flowid_yumi,
    input  logic [NUM_CTRL-1:0]          ctrl_sched_requeue_val,
    input  logic [NUM_CTRL*FLOWID_W-1:0] ctrl_sched_requeue_flowid,
    output logic [NUM_CTRL-1:0]          sched_ctrl_requeue_rdy,
    output logic [NUM_CTRL-1:0]          sched_busy_mask,
    output logic                         sched_idle
);

    localparam int PTR_W = $clog2(NUM_CTRL);

    logic [NUM_CTRL-1:0] busyMask_q, busyMask_d;
    logic [PTR_W-1:0]    dispPtr_q, dispPtr_d;
    logic [PTR_W-1:0]    rqPtr_q, rqPtr_d;
    logic [PTR_W-1:0]    rqLockIdx_q, rqLockIdx_d;
    logic                rqLock_q, rqLock_d;

    logic [NUM_CTRL-1:0] dispGrant, rqGrant;
    logic [PTR_W-1:0]    dispIdx, rqIdx;
    logic                dispAny, rqAny;
    logic                offer, dispHs, rqHs;

    flow_rr_arb #(.N(NUM_CTRL), .PW(PTR_W)) u_disp_arb (
        .req_i      (~busyMask_q),
        .ptr_i      (dispPtr_q),
        .lock_i     (1'b0),
        .lock_idx_i ('0),
        .grant_o    (dispGrant),
        .idx_o      (dispIdx),
        .any_o      (dispAny)
    );

    flow_rr_arb #(.N(NUM_CTRL), .PW(PTR_W)) u_rq_arb (
        .req_i      (ctrl_sched_requeue_val),
        .ptr_i      (rqPtr_q),
        .lock_i     (rqLock_q),
        .lock_idx_i (rqLockIdx_q),
        .grant_o    (rqGrant),
        .idx_o      (rqIdx),
        .any_o      (rqAny)
    );

    assign offer                       = sched_en & flow_fifo_sched_flowid_val & dispAny;
    assign sched_ctrl_flowid_val       = offer ? dispGrant : '0;
    assign sched_ctrl_flowid           = flow_fifo_sched_flowid;
    assign dispHs                      = offer & ctrl_sched_flowid_yumi[dispIdx];
    assign sched_flow_fifo_flowid_yumi = dispHs;

    assign sched_flow_fifo_enqueue_val = rqAny & ctrl_sched_requeue_val[rqIdx];
    assign rqHs                        = sched_flow_fifo_enqueue_val & flow_fifo_sched_enqueue_rdy;
    assign sched_ctrl_requeue_rdy      = sched_flow_fifo_enqueue_val ?
                                         (rqGrant & {NUM_CTRL{flow_fifo_sched_enqueue_rdy}}) : '0;

    assign sched_busy_mask = busyMask_q;
    assign sched_idle      = ~|busyMask_q;

    // Select the granted controller's slice of the requeue flow ID bus.
    always_comb begin
        sched_flow_fifo_enqueue_flowid = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (rqIdx == PTR_W'(i)) begin
                sched_flow_fifo_enqueue_flowid = ctrl_sched_requeue_flowid[i*FLOWID_W +: FLOWID_W];
            end
        end
    end

    // Next state: busy set/clear on handshakes, pointer advance, requeue lock.
    always_comb begin
        busyMask_d  = busyMask_q;
        dispPtr_d   = dispPtr_q;
        rqPtr_d     = rqPtr_q;
        rqLock_d    = rqLock_q;
        rqLockIdx_d = rqLockIdx_q;
        if (dispHs) begin
            busyMask_d = busyMask_d | dispGrant;
            dispPtr_d  = dispIdx + PTR_W'(1);
        end
        if (rqHs) begin
            busyMask_d = busyMask_d & ~rqGrant;
            rqPtr_d    = rqIdx + PTR_W'(1);
            rqLock_d   = 1'b0;
        end else if (sched_flow_fifo_enqueue_val) begin
            rqLock_d    = 1'b1;
            rqLockIdx_d = rqIdx;
        end
    end

    // State registers; reset drops any in-flight grant without completing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busyMask_q  <= '0;
            dispPtr_q   <= '0;
            rqPtr_q     <= '0;
            rqLock_q    <= 1'b0;
            rqLockIdx_q <= '0;
        end else begin
            busyMask_q  <= busyMask_d;
            dispPtr_q   <= dispPtr_d;
            rqPtr_q     <= rqPtr_d;
            rqLock_q    <= rqLock_d;
            rqLockIdx_q <= rqLockIdx_d;
        end
    end

endmodule

// File: tb/tb_rpc_echo_app_flow_sched.sv
// Self-checking bench for rpc_echo_app_flow_sched: a cycle-by-cycle vector
// table plus hand-built drain and reset sequences, with scoreboards for the
// dispatched and requeued flow IDs.
module tb_rpc_echo_app_flow_sched;

    logic        clk;
    logic        rst;
    logic        schedEn;
    logic        fifoVal;
    logic [7:0]  fifoId;
    logic        fifoYumi;
    logic        enqVal;
    logic [7:0]  enqId;
    logic        enqRdy;
    logic [3:0]  ctrlVal;
    logic [7:0]  ctrlId;
    logic [3:0]  ctrlYumi;
    logic [3:0]  rqVal;
    logic [31:0] rqIds;
    logic [3:0]  rqRdy;
    logic [3:0]  busyMask;
    logic        idle;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] dispQ[$];
    logic [7:0] enqQ[$];

    typedef struct packed {
        logic        en;
        logic        fv;
        logic [7:0]  fid;
        logic [3:0]  yumi;
        logic [3:0]  rqv;
        logic [31:0] rqIds;
        logic        rdy;
        logic [3:0]  expVal;
        logic        expYumi;
        logic        expEnqV;
        logic [7:0]  expEnqId;
        logic [3:0]  expRqRdy;
        logic [3:0]  expBusy;
    } vec_t;

    vec_t vecs[19];

    rpc_echo_app_flow_sched #(.NUM_CTRL(4), .FLOWID_W(8)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .sched_en                       (schedEn),
        .flow_fifo_sched_flowid_val     (fifoVal),
        .flow_fifo_sched_flowid         (fifoId),
        .sched_flow_fifo_flowid_yumi    (fifoYumi),
        .sched_flow_fifo_enqueue_val    (enqVal),
        .sched_flow_fifo_enqueue_flowid (enqId),
        .flow_fifo_sched_enqueue_rdy    (enqRdy),
        .sched_ctrl_flowid_val          (ctrlVal),
        .sched_ctrl_flowid              (ctrlId),
        .ctrl_sched_flowid_yumi         (ctrlYumi),
        .ctrl_sched_requeue_val         (rqVal),
        .ctrl_sched_requeue_flowid      (rqIds),
        .sched_ctrl_requeue_rdy         (rqRdy),
        .sched_busy_mask                (busyMask),
        .sched_idle                     (idle)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic fv, input logic [7:0] fid,
                                input logic [3:0] yumi, input logic [3:0] rqv,
                                input logic [31:0] ids, input logic rdy,
                                input logic [3:0] eVal, input logic eYumi,
                                input logic eEnqV, input logic [7:0] eEnqId,
                                input logic [3:0] eRqRdy, input logic [3:0] eBusy);
        return '{en, fv, fid, yumi, rqv, ids, rdy, eVal, eYumi, eEnqV, eEnqId, eRqRdy, eBusy};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        schedEn  = v.en;
        fifoVal  = v.fv;
        fifoId   = v.fid;
        ctrlYumi = v.yumi;
        rqVal    = v.rqv;
        rqIds    = v.rqIds;
        enqRdy   = v.rdy;
    endtask

    task automatic scoreboardSample();
        if (fifoYumi) begin
            checkOutput("dispatch scoreboard nonempty", 32'(dispQ.size() > 0), 32'd1);
            if (dispQ.size() > 0) checkOutput("dispatch flowid", 32'(ctrlId), 32'(dispQ.pop_front()));
        end
        if (enqVal && enqRdy) begin
            checkOutput("requeue scoreboard nonempty", 32'(enqQ.size() > 0), 32'd1);
            if (enqQ.size() > 0) checkOutput("requeue flowid", 32'(enqId), 32'(enqQ.pop_front()));
        end
    endtask

    task automatic runVec(input vec_t v, input string tag);
        @(negedge clk);
        applyStimulus(v);
        #1;
        if (v.expYumi) dispQ.push_back(v.fid);
        if (v.expEnqV && v.rdy) enqQ.push_back(v.expEnqId);
        checkOutput({tag, " offer val"},   32'(ctrlVal),  32'(v.expVal));
        checkOutput({tag, " fifo yumi"},   32'(fifoYumi), 32'(v.expYumi));
        checkOutput({tag, " enqueue val"}, 32'(enqVal),   32'(v.expEnqV));
        if (v.expEnqV) checkOutput({tag, " enqueue id"}, 32'(enqId), 32'(v.expEnqId));
        checkOutput({tag, " requeue rdy"}, 32'(rqRdy),    32'(v.expRqRdy));
        checkOutput({tag, " busy mask"},   32'(busyMask), 32'(v.expBusy));
        checkOutput({tag, " idle"},        32'(idle),     32'(v.expBusy == 4'b0000));
        checkOutput({tag, " yumi only from target"},
                    32'(!fifoYumi || ((ctrlVal & ctrlYumi) != 4'b0000)), 32'd1);
        scoreboardSample();
    endtask

    // Main sequence: reset, vector table, drain with dispatch disabled, reset mid-flight.
    initial begin
        vec_t v;
        rst = 1'b1;
        applyStimulus('0);

        //          en  fv  fid    yumi     rqv      ids           rdy | val     yumi eV  eId    rqRdy    busy
        vecs[0]  = mk(1, 1, 8'h11, 4'b0000, 4'b0000, 32'h0,        0,  4'b0001, 0,  0, 8'h00, 4'b0000, 4'b0000);
        vecs[1]  = mk(1, 1, 8'h11, 4'b0001, 4'b0000, 32'h0,        0,  4'b0001, 1,  0, 8'h00, 4'b0000, 4'b0000);
        vecs[2]  = mk(1, 1, 8'h22, 4'b0010, 4'b0000, 32'h0,        0,  4'b0010, 1,  0, 8'h00, 4'b0000, 4'b0001);
        vecs[3]  = mk(1, 1, 8'h33, 4'b1000, 4'b0000, 32'h0,        0,  4'b0100, 0,  0, 8'h00, 4'b0000, 4'b0011);
        vecs[4]  = mk(1, 1, 8'h33, 4'b0100, 4'b0000, 32'h0,        0,  4'b0100, 1,  0, 8'h00, 4'b0000, 4'b0011);
        vecs[5]  = mk(1, 1, 8'h44, 4'b1000, 4'b0000, 32'h0,        0,  4'b1000, 1,  0, 8'h00, 4'b0000, 4'b0111);
        vecs[6]  = mk(1, 1, 8'h55, 4'b0000, 4'b0000, 32'h0,        0,  4'b0000, 0,  0, 8'h00, 4'b0000, 4'b1111);
        vecs[7]  = mk(1, 1, 8'h55, 4'b0000, 4'b0100, 32'h00330000, 1,  4'b0000, 0,  1, 8'h33, 4'b0100, 4'b1111);
        vecs[8]  = mk(1, 1, 8'h55, 4'b0100, 4'b0000, 32'h0,        0,  4'b0100, 1,  0, 8'h00, 4'b0000, 4'b1011);
        vecs[9]  = mk(1, 0, 8'h00, 4'b0000, 4'b1000, 32'h44000000, 1,  4'b0000, 0,  1, 8'h44, 4'b1000, 4'b1111);
        vecs[10] = mk(1, 1, 8'h66, 4'b1000, 4'b0000, 32'h0,        0,  4'b1000, 1,  0, 8'h00, 4'b0000, 4'b0111);
        vecs[11] = mk(1, 0, 8'h00, 4'b0000, 4'b1010, 32'h66002200, 0,  4'b0000, 0,  1, 8'h22, 4'b0000, 4'b1111);
        vecs[12] = mk(1, 0, 8'h00, 4'b0000, 4'b1010, 32'h66002200, 0,  4'b0000, 0,  1, 8'h22, 4'b0000, 4'b1111);
        vecs[13] = mk(1, 0, 8'h00, 4'b0000, 4'b1011, 32'h66002277, 0,  4'b0000, 0,  1, 8'h22, 4'b0000, 4'b1111);
        vecs[14] = mk(1, 0, 8'h00, 4'b0000, 4'b1011, 32'h66002277, 1,  4'b0000, 0,  1, 8'h22, 4'b0010, 4'b1111);
        vecs[15] = mk(1, 0, 8'h00, 4'b0000, 4'b1001, 32'h66002277, 1,  4'b0000, 0,  1, 8'h66, 4'b1000, 4'b1101);
        vecs[16] = mk(1, 1, 8'h88, 4'b0010, 4'b0001, 32'h00000077, 1,  4'b0010, 1,  1, 8'h77, 4'b0001, 4'b0101);
        vecs[17] = mk(0, 1, 8'h99, 4'b0000, 4'b0100, 32'h00550000, 1,  4'b0000, 0,  1, 8'h55, 4'b0100, 4'b0110);
        vecs[18] = mk(1, 0, 8'h00, 4'b0000, 4'b0000, 32'h0,        1,  4'b0000, 0,  0, 8'h00, 4'b0000, 4'b0010);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Dispatch disabled for 10 cycles while ctrl1 drains its flow.
        for (int c = 0; c < 10; c++) begin
            v = mk(0, 1, 8'hAB, 4'b0000, (c == 3) ? 4'b0010 : 4'b0000, 32'h00002200, 1,
                   4'b0000, 0, (c == 3), 8'h22, (c == 3) ? 4'b0010 : 4'b0000,
                   (c <= 3) ? 4'b0010 : 4'b0000);
            runVec(v, $sformatf("drain%0d", c));
        end

        // Build a pending offer and a locked requeue, then reset over them.
        runVec(mk(1, 1, 8'hC1, 4'b0100, 4'b0000, 32'h0, 0,
                  4'b0100, 1, 0, 8'h00, 4'b0000, 4'b0000), "pre-reset dispatch");
        runVec(mk(1, 1, 8'hC2, 4'b0000, 4'b0100, 32'h005A0000, 0,
                  4'b1000, 0, 1, 8'h5A, 4'b0000, 4'b0100), "pre-reset pending");
        @(negedge clk);
        rst = 1'b1;
        runVec(mk(0, 0, 8'h00, 4'b0000, 4'b0000, 32'h0, 0,
                  4'b0000, 0, 0, 8'h00, 4'b0000, 4'b0000), "in reset");
        rst = 1'b0;
        runVec(mk(1, 1, 8'hD0, 4'b0001, 4'b0000, 32'h0, 0,
                  4'b0001, 1, 0, 8'h00, 4'b0000, 4'b0000), "post-reset ctrl0");
        runVec(mk(1, 1, 8'hD1, 4'b0010, 4'b0000, 32'h0, 0,
                  4'b0010, 1, 0, 8'h00, 4'b0000, 4'b0001), "post-reset ctrl1");

        @(negedge clk);
        applyStimulus('0);
        checkOutput("dispatch scoreboard drained", 32'(dispQ.size()), 32'd0);
        checkOutput("requeue scoreboard drained",  32'(enqQ.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
